control_unit: RTL and testbench
===============================

# control_unit

Micro-sequencer of the RW-Pioneer core, directly upstream of the ALU. It fetches 3-nibble instructions from nibble-addressed memory, holds PC and the instruction register, and drives the memory strobes, the shared data bus and the ALU micro-instruction each cycle. It also samples the ALU zero flag to resolve conditional jumps.

## Interface

- Parameters: none. Widths come from `defines.vh`: `WORD_SIZE` = 4, `ALU_MICRO_INSTRUCTION_SIZE`. The address width is fixed at 8.
- Ports:
- clk  in  1  core clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- bus_in  in  `WORD_SIZE`  shared data bus (memory read data OR ALU bus_out)
- zero_flag  in  1  ALU zero flag
- bus_out  out  `WORD_SIZE`  immediate operand driven onto the bus; '0 when not driving (OR-bus)
- alu_instruction  out  `ALU_MICRO_INSTRUCTION_SIZE`  micro-op to ALU; `ALU_NOP` when idle
- mem_addr  out  8  memory nibble address
- mem_rd  out  1  memory drives bus_in combinationally this cycle
- mem_wr  out  1  memory captures bus_in at next posedge
- halted  out  1  core stopped by HLT
- step  in  1  single-step advance (only with `RWP_SINGLE_STEP_EN`)

## Operation

- Instruction format: nibble 0 = opcode, nibble 1 = operand[7:4], nibble 2 = operand[3:0], stored at PC, PC+1, PC+2.
- Opcodes:
  - 0x0 NOP.
  - 0x1 LDA: mem[op]→ACC via `ALU_BUSTOACC`.
  - 0x2 STA: ACC→mem[op] via `ALU_ACCTOBUS` + mem_wr.
  - 0x3 ADD, 0x4 ADDC, 0x5 SUB, 0x6 SUBC: mem[op] is the operand; mem_rd + matching ALU op.
  - 0x7 LDI: bus_out = op[3:0], `ALU_BUSTOACC`.
  - 0x8 JMP: PC←op.
  - 0x9 JZ: PC←op if zero_flag = 1.
  - 0xF HLT.
  - 0xA–0xE execute as NOP.
- FSM states: FETCH_OP → FETCH_HI → FETCH_LO → EXEC → FETCH_OP. HLT in EXEC → HALT; HALT is left only by reset.
- FETCH_*: mem_rd = 1, mem_addr = PC; nibble latched into IR at posedge; PC ← PC+1.
- EXEC: mem_addr = operand for memory ops, else PC. Strobes and ALU op are per the opcode table; all other outputs are idle.
- PC arithmetic is 8-bit modulo: 0xFF+1 = 0x00. An instruction may straddle the wrap.
- JZ samples zero_flag in EXEC. The flag reflects the last arithmetic op, which completed at least 4 cycles earlier.
- mem_rd and mem_wr are never both 1.
- bus_out is nonzero only in EXEC of LDI.
- Idle outputs: alu_instruction = `ALU_NOP`, bus_out = 0, strobes = 0.

## Timing

- Every instruction takes exactly 4 cycles (3 fetch + 1 exec), plus step wait if enabled.
- All outputs decode combinationally from state/IR/PC. No output depends combinationally on bus_in.
- ALU and memory effects land at the posedge ending EXEC.
- Reset assertion takes effect immediately and asynchronously:
  - state = FETCH_OP, PC = 0x00, IR = 0.
  - While reset = 1, all outputs are forced to idle: mem_rd = 0, mem_wr = 0, mem_addr = 0x00, bus_out = 0, alu_instruction = `ALU_NOP`, halted = 0.
- Reset mid-instruction abandons the instruction; no partial write occurs after reset.
- First fetch (mem_addr = 0x00, mem_rd = 1) occurs in the first cycle after reset deasserts.
- HALT: halted = 1 from the cycle after HLT's EXEC. All strobes stay 0 and PC is frozen.

## Configuration

- `RWP_SINGLE_STEP_EN` defined:
  - Port step exists; EXEC → STEP_WAIT (idle outputs, PC held).
  - STEP_WAIT → FETCH_OP in the cycle after step is sampled 1.
  - step is level-sampled; holding it high runs at 5 cycles per instruction.
  - HLT still goes to HALT.
- Not defined: no step port, no STEP_WAIT state; EXEC → FETCH_OP directly.

## Test plan

- Reset, program `7 0 5`, `F 0 0` → cycle 3: bus_out = 0x5, alu_instruction = `ALU_BUSTOACC`. halted = 1 from cycle 8 onward, mem_addr frozen.
- Program `7 0 9`, `2 4 0`, `F 0 0` → mem[0x40] = 0x9 after cycle 7. mem_wr high exactly one cycle, with mem_addr = 0x40.
- mem[0x80] = 0x3; program `7 0 3`, `5 8 0`, `9 2 0`, `F 0 0`; mem[0x20] = `F` → ACC = 0, the JZ is taken, and halt occurs at address 0x20.
- Same program with mem[0x80] = 0x2 → JZ not taken; fetch continues at 0x09.
- PC = 0xFE with NOPs → fetch addresses 0xFE, 0xFF, 0x00, then EXEC; next fetch at 0x01.
- Assert reset during EXEC of STA → mem_wr drops immediately, no write occurs, and mem_addr = 0x00 in the cycle after release.
- With the macro enabled, step held at 0 → the FSM stays in STEP_WAIT indefinitely. A one-cycle step pulse → exactly one further instruction executes.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: RW-Pioneer micro-sequencer; fetches 3-nibble instructions, drives memory and ALU.
// Optional single-step mode when RWP_SINGLE_STEP_EN is defined.
`ifndef WORD_SIZE
`define WORD_SIZE 4
`endif
`ifndef ALU_MICRO_INSTRUCTION_SIZE
`define ALU_MICRO_INSTRUCTION_SIZE 4
`define ALU_NOP      4'd0
`define ALU_BUSTOACC 4'd1
`define ALU_ACCTOBUS 4'd2
`define ALU_ADD      4'd3
`define ALU_ADDC     4'd4
`define ALU_SUB      4'd5
`define ALU_SUBC     4'd6
`endif

module control_unit (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [`WORD_SIZE-1:0]                  bus_in,
    input  logic                                   zero_flag,
    output logic [`WORD_SIZE-1:0]                  bus_out,
    output logic [`ALU_MICRO_INSTRUCTION_SIZE-1:0] alu_instruction,
    output logic [7:0]                             mem_addr,
    output logic                                   mem_rd,
    output logic                                   mem_wr,
    output logic                                   halted
`ifdef RWP_SINGLE_STEP_EN
    ,
    input  logic                                   step
`endif
);

    localparam logic [2:0] FETCH_OP  = 3'd0;
    localparam logic [2:0] FETCH_HI  = 3'd1;
    localparam logic [2:0] FETCH_LO  = 3'd2;
    localparam logic [2:0] EXEC      = 3'd3;
    localparam logic [2:0] HALT      = 3'd4;
`ifdef RWP_SINGLE_STEP_EN
    localparam logic [2:0] STEP_WAIT = 3'd5;
`endif

    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_STA  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_ADDC = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_SUBC = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_HLT  = 4'hF;

    logic [2:0]  state;
    logic [7:0]  pc;
    logic [11:0] ir;
    logic [3:0]  opcode;
    logic [7:0]  operand;

    assign opcode  = ir[11:8];
    assign operand = ir[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH_OP;
            pc    <= 8'h00;
            ir    <= 12'h000;
        end else begin
            unique case (state)
                FETCH_OP: begin
                    ir[11:8] <= bus_in;
                    pc       <= pc + 8'd1;
                    state    <= FETCH_HI;
                end
                FETCH_HI: begin
                    ir[7:4] <= bus_in;
                    pc      <= pc + 8'd1;
                    state   <= FETCH_LO;
                end
                FETCH_LO: begin
                    ir[3:0] <= bus_in;
                    pc      <= pc + 8'd1;
                    state   <= EXEC;
                end
                EXEC: begin
                    if (opcode == OP_JMP || (opcode == OP_JZ && zero_flag))
                        pc <= operand;
                    if (opcode == OP_HLT)
                        state <= HALT;
                    else
`ifdef RWP_SINGLE_STEP_EN
                        state <= STEP_WAIT;
`else
                        state <= FETCH_OP;
`endif
                end
                HALT: state <= HALT;
`ifdef RWP_SINGLE_STEP_EN
                STEP_WAIT: if (step) state <= FETCH_OP;
`endif
                default: state <= FETCH_OP;
            endcase
        end
    end

    always_comb begin
        mem_rd          = 1'b0;
        mem_wr          = 1'b0;
        mem_addr        = pc;
        bus_out         = '0;
        alu_instruction = `ALU_NOP;
        halted          = 1'b0;
        unique case (state)
            FETCH_OP, FETCH_HI, FETCH_LO: mem_rd = 1'b1;
            EXEC: begin
                unique case (opcode)
                    OP_LDA: begin
                        mem_addr        = operand;
                        mem_rd          = 1'b1;
                        alu_instruction = `ALU_BUSTOACC;
                    end
                    OP_STA: begin
                        mem_addr        = operand;
                        mem_wr          = 1'b1;
                        alu_instruction = `ALU_ACCTOBUS;
                    end
                    OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
                        mem_addr = operand;
                        mem_rd   = 1'b1;
                        unique case (opcode)
                            OP_ADD:  alu_instruction = `ALU_ADD;
                            OP_ADDC: alu_instruction = `ALU_ADDC;
                            OP_SUB:  alu_instruction = `ALU_SUB;
                            default: alu_instruction = `ALU_SUBC;
                        endcase
                    end
                    OP_LDI: begin
                        bus_out         = operand[3:0];
                        alu_instruction = `ALU_BUSTOACC;
                    end
                    default: ;
                endcase
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
        // State resets asynchronously to FETCH_OP, so outputs must be gated too.
        if (reset) begin
            mem_rd          = 1'b0;
            mem_wr          = 1'b0;
            mem_addr        = 8'h00;
            bus_out         = '0;
            alu_instruction = `ALU_NOP;
            halted          = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed bench with nibble memory and accumulator ALU models.
// Build with RWP_SINGLE_STEP_EN to also exercise single-step mode.
`ifndef WORD_SIZE
`define WORD_SIZE 4
`endif
`ifndef ALU_MICRO_INSTRUCTION_SIZE
`define ALU_MICRO_INSTRUCTION_SIZE 4
`define ALU_NOP      4'd0
`define ALU_BUSTOACC 4'd1
`define ALU_ACCTOBUS 4'd2
`define ALU_ADD      4'd3
`define ALU_ADDC     4'd4
`define ALU_SUB      4'd5
`define ALU_SUBC     4'd6
`endif

module tb_control_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic step = 1'b0;
    logic zero_flag;
    logic [3:0] bus_in, bus_out;
    logic [`ALU_MICRO_INSTRUCTION_SIZE-1:0] alu_instruction;
    logic [7:0] mem_addr;
    logic mem_rd, mem_wr, halted;

    logic [3:0] mem [256];
    logic [3:0] img [256];
    logic load = 1'b0;
    logic [3:0] acc, mem_data, alu_out;
    logic carry, zero;
    logic [4:0] res;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk),
        .reset(reset),
        .bus_in(bus_in),
        .zero_flag(zero_flag),
        .bus_out(bus_out),
        .alu_instruction(alu_instruction),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr),
        .halted(halted)
`ifdef RWP_SINGLE_STEP_EN
        ,
        .step(step)
`endif
    );

    assign mem_data  = mem_rd ? mem[mem_addr] : 4'h0;
    assign alu_out   = (alu_instruction == `ALU_ACCTOBUS) ? acc : 4'h0;
    assign bus_in    = mem_data | alu_out | bus_out;
    assign zero_flag = zero;

    always_comb begin
        res = {1'b0, acc};
        case (alu_instruction)
            `ALU_ADD:  res = {1'b0, acc} + {1'b0, bus_in};
            `ALU_ADDC: res = {1'b0, acc} + {1'b0, bus_in} + {4'b0, carry};
            `ALU_SUB:  res = {1'b0, acc} - {1'b0, bus_in};
            `ALU_SUBC: res = {1'b0, acc} - {1'b0, bus_in} - {4'b0, carry};
            default:   res = {1'b0, acc};
        endcase
    end

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
            acc   <= 4'h0;
            carry <= 1'b0;
            zero  <= 1'b0;
        end else begin
            if (mem_wr) mem[mem_addr] <= bus_in;
            case (alu_instruction)
                `ALU_BUSTOACC: acc <= bus_in;
                `ALU_ADD, `ALU_ADDC, `ALU_SUB, `ALU_SUBC: begin
                    acc   <= res[3:0];
                    carry <= res[4];
                    zero  <= (res[3:0] == 4'h0);
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 4'h0;
    endtask

    // Loads img and resets; returns sampling cycle 0 (first fetch).
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int wr_count;

    initial begin
        clear_img();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        #1;
        check("rst_mem_rd", mem_rd, 0);
        check("rst_addr", mem_addr, 8'h00);
        check("rst_alu", alu_instruction, `ALU_NOP);
        check("rst_halted", halted, 0);

        // LDI 5 ; HLT
        clear_img();
        img[0] = 4'h7; img[1] = 4'h0; img[2] = 4'h5; img[3] = 4'hF;
        do_reset();
        check("t1_c0_addr", mem_addr, 8'h00);
        check("t1_c0_rd", mem_rd, 1);
        cycles(3);
        check("t1_c3_bus", bus_out, 8'h05);
        check("t1_c3_alu", alu_instruction, `ALU_BUSTOACC);
        check("t1_c3_rd", mem_rd, 0);
        cycles(4);
        check("t1_c7_halted", halted, 0);
        cycles(1);
        check("t1_c8_halted", halted, 1);
        check("t1_c8_addr", mem_addr, 8'h06);
        cycles(4);
        check("t1_c12_halted", halted, 1);
        check("t1_c12_addr", mem_addr, 8'h06);
        check("t1_c12_rd", mem_rd, 0);
        check("t1_acc", acc, 8'h05);

        // LDI 9 ; STA 0x40 ; HLT
        clear_img();
        img[0] = 4'h7; img[1] = 4'h0; img[2] = 4'h9;
        img[3] = 4'h2; img[4] = 4'h4; img[5] = 4'h0;
        img[6] = 4'hF;
        do_reset();
        wr_count = 0;
        cycles(6);
        check("t2_c6_wr", mem_wr, 0);
        cycles(1);
        check("t2_c7_wr", mem_wr, 1);
        check("t2_c7_addr", mem_addr, 8'h40);
        check("t2_c7_rd", mem_rd, 0);
        check("t2_c7_alu", alu_instruction, `ALU_ACCTOBUS);
        cycles(1);
        check("t2_mem40", mem[8'h40], 8'h09);
        do_reset();
        for (int i = 0; i < 14; i++) begin
            if (mem_wr) wr_count++;
            cycles(1);
        end
        check("t2_wr_count", wr_count[7:0], 8'd1);

        // LDI 3 ; SUB [0x80] ; JZ 0x20 ; HLT, with HLT at 0x20
        clear_img();
        img[0] = 4'h7; img[1] = 4'h0; img[2] = 4'h3;
        img[3] = 4'h5; img[4] = 4'h8; img[5] = 4'h0;
        img[6] = 4'h9; img[7] = 4'h2; img[8] = 4'h0;
        img[9] = 4'hF;
        img[8'h20] = 4'hF;
        img[8'h80] = 4'h3;
        do_reset();
        cycles(7);
        check("t3_c7_alu", alu_instruction, `ALU_SUB);
        check("t3_c7_addr", mem_addr, 8'h80);
        check("t3_c7_rd", mem_rd, 1);
        cycles(1);
        check("t3_acc", acc, 8'h00);
        check("t3_zero", zero_flag, 1);
        cycles(4);
        check("t3_jz_taken", mem_addr, 8'h20);
        cycles(4);
        check("t3_halted", halted, 1);
        check("t3_halt_addr", mem_addr, 8'h23);

        img[8'h80] = 4'h2;
        do_reset();
        cycles(8);
        check("t4_acc", acc, 8'h01);
        check("t4_zero", zero_flag, 0);
        cycles(4);
        check("t4_jz_not_taken", mem_addr, 8'h09);

        // JMP 0xFE ; NOP straddling the wrap
        clear_img();
        img[0] = 4'h8; img[1] = 4'hF; img[2] = 4'hE;
        do_reset();
        cycles(4);
        check("t5_c4_addr", mem_addr, 8'hFE);
        cycles(1);
        check("t5_c5_addr", mem_addr, 8'hFF);
        cycles(1);
        check("t5_c6_addr", mem_addr, 8'h00);
        check("t5_c6_rd", mem_rd, 1);
        cycles(1);
        check("t5_c7_rd", mem_rd, 0);
        cycles(1);
        check("t5_c8_addr", mem_addr, 8'h01);
        check("t5_c8_rd", mem_rd, 1);

        // Reset during EXEC of STA
        clear_img();
        img[0] = 4'h7; img[1] = 4'h0; img[2] = 4'h9;
        img[3] = 4'h2; img[4] = 4'h4; img[5] = 4'h0;
        do_reset();
        cycles(7);
        check("t6_pre_wr", mem_wr, 1);
        reset = 1'b1;
        #1;
        check("t6_wr_drop", mem_wr, 0);
        check("t6_addr_rst", mem_addr, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_mem40", mem[8'h40], 8'h00);
        check("t6_post_addr", mem_addr, 8'h00);
        check("t6_post_rd", mem_rd, 1);

`ifdef RWP_SINGLE_STEP_EN
        // LDI 5 ; NOP ; NOP under single-step control
        clear_img();
        img[0] = 4'h7; img[1] = 4'h0; img[2] = 4'h5;
        step = 1'b0;
        do_reset();
        cycles(4);
        check("s_wait_rd", mem_rd, 0);
        check("s_wait_addr", mem_addr, 8'h03);
        cycles(6);
        check("s_hold_rd", mem_rd, 0);
        check("s_hold_addr", mem_addr, 8'h03);
        step = 1'b1;
        cycles(1);
        step = 1'b0;
        check("s_f0_addr", mem_addr, 8'h03);
        check("s_f0_rd", mem_rd, 1);
        cycles(2);
        check("s_f2_addr", mem_addr, 8'h05);
        cycles(2);
        check("s_wait2_rd", mem_rd, 0);
        check("s_wait2_addr", mem_addr, 8'h06);
        cycles(5);
        check("s_wait3_rd", mem_rd, 0);
        check("s_wait3_addr", mem_addr, 8'h06);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
